// File: rtl/vec_data_mem_burst.sv
// Vector data memory with burst read/write, per-lane write mask, registered read port
// with valid/ready backpressure, address wrap and a sticky out-of-range error flag.
module vec_data_mem_burst #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8,
  parameter int DEPTH  = 10925,
  parameter int ADDR_W = 17,
  parameter int LEN_W  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [LEN_W-1:0]                 req_len,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [LANES-1:0][LANE_W-1:0]     wr_data,
  input  logic [LANES-1:0]                 wr_mask,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [LANES-1:0][LANE_W-1:0]     rd_data,
  output logic                             rd_last,
  output logic                             err_oob
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          state_nxt_s;
  logic [ADDR_W-1:0]               cur_addr_r;
  logic [ADDR_W-1:0]               adv_addr_s;
  logic [LEN_W-1:0]                cnt_r;
  logic                            burst_oob_r;
  logic                            req_oob_s;
  logic                            accept_s;
  logic                            wr_beat_s;
  logic                            issue_s;
  logic                            last_s;
  logic [IDX_W-1:0]                idx_s;
  logic [LANES-1:0][LANE_W-1:0]    ram_q_s;
  logic                            req_ready_r;
  logic                            wr_ready_r;
  logic                            rd_valid_r;
  logic                            rd_last_r;
  logic                            err_oob_r;
  logic [LANES-1:0][LANE_W-1:0]    rd_data_r;

  assign req_ready = req_ready_r;
  assign wr_ready  = wr_ready_r;
  assign rd_valid  = rd_valid_r;
  assign rd_last   = rd_last_r;
  assign rd_data   = rd_data_r;
  assign err_oob   = err_oob_r;

  // Transaction strobes and the wrapping address step.
  always_comb begin
    accept_s  = (state_r == IDLE) && req_valid;
    req_oob_s = ({1'b0, req_addr} >= DEPTH_X);
    wr_beat_s = (state_r == WRITE) && wr_valid;
    issue_s   = (state_r == READ) && (!rd_valid_r || rd_ready);
    last_s    = (cnt_r == LEN_W'(0));
    idx_s     = IDX_W'(cur_addr_r);
    if (cur_addr_r == LAST_ADDR) begin
      adv_addr_s = ADDR_W'(0);
    end else begin
      adv_addr_s = cur_addr_r + ADDR_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = req_we ? WRITE : READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (wr_beat_s && last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (issue_s && last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = READ;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; ready flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      wr_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= (state_nxt_s == IDLE);
      wr_ready_r  <= (state_nxt_s == WRITE);
    end
  end

  // Burst address/count tracking and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_r  <= ADDR_W'(0);
      cnt_r       <= LEN_W'(0);
      burst_oob_r <= 1'b0;
      err_oob_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        cur_addr_r  <= req_addr;
        cnt_r       <= req_len;
        burst_oob_r <= req_oob_s;
      end else if ((wr_beat_s || issue_s) && !last_s) begin
        cnt_r      <= cnt_r - LEN_W'(1);
        cur_addr_r <= adv_addr_s;
      end
      if (accept_s && req_oob_s) begin
        err_oob_r <= 1'b1;
      end
    end
  end

  // One narrow RAM per lane so the lane mask maps onto independent write enables.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_beat_s && !burst_oob_r && wr_mask[g]) begin
        lane_mem[idx_s] <= wr_data[g];
      end
    end

    assign ram_q_s[g] = lane_mem[idx_s];
  end

  // Registered read port; a stalled beat holds until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      rd_data_r  <= {(LANES*LANE_W){1'b0}};
    end else begin
      if (issue_s) begin
        rd_data_r  <= burst_oob_r ? {(LANES*LANE_W){1'b0}} : ram_q_s;
        rd_valid_r <= 1'b1;
        rd_last_r  <= last_s;
      end else if (rd_valid_r && rd_ready) begin
        rd_valid_r <= 1'b0;
        rd_last_r  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_data_mem_burst.sv
// Randomised self-checking bench for vec_data_mem_burst against a word-array reference
// model addressed with modular arithmetic.
module tb_vec_data_mem_burst;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 10925;
  localparam int ADDR_W = 17;
  localparam int LEN_W  = 4;
  localparam int W      = LANES * LANE_W;
  localparam int IW     = $clog2(DEPTH);

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [W-1:0]      wr_data;
  logic [LANES-1:0]  wr_mask;
  logic              rd_valid;
  logic              rd_ready;
  logic [W-1:0]      rd_data;
  logic              rd_last;
  logic              err_oob;

  vec_data_mem_burst #(
    .LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .err_oob(err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               checks;
  int               failures;
  logic             exp_err;
  logic [W-1:0]     ref_mem [DEPTH];
  logic [W-1:0]     known   [DEPTH];
  logic [W-1:0]     wbuf    [16];
  logic [LANES-1:0] mbuf    [16];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_expand(input logic [LANES-1:0] m);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = {LANE_W{m[i]}};
    return r;
  endfunction

  task automatic do_req(input logic we, input int addr, input int len);
    int n;
    req_we    = we;
    req_addr  = ADDR_W'(addr);
    req_len   = LEN_W'(len);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (addr >= DEPTH) exp_err = 1'b1;
  endtask

  task automatic write_burst(input int addr, input int len, input bit gaps);
    int           a;
    logic [W-1:0] m;
    do_req(1'b1, addr, len);
    for (int k = 0; k <= len; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          wr_valid = 1'b0;
          wr_data  = W'({$urandom(), $urandom()});
          wr_mask  = LANES'($urandom());
          @(posedge clk); #1;
        end
      end
      wr_valid = 1'b1;
      wr_data  = wbuf[4'(k)];
      wr_mask  = mbuf[4'(k)];
      check_eq("wr_ready", 64'(wr_ready), 64'd1);
      @(posedge clk); #1;
      if (addr < DEPTH) begin
        a = (addr + k) % DEPTH;
        m = lane_expand(mbuf[4'(k)]);
        ref_mem[IW'(a)] = (ref_mem[IW'(a)] & ~m) | (wbuf[4'(k)] & m);
        known[IW'(a)]   = known[IW'(a)] | m;
      end
    end
    wr_valid = 1'b0;
    check_eq("wr_done_idle", 64'(req_ready), 64'd1);
  endtask

  // mode 0: rd_ready held high; 1: random; 2: three stall cycles after the first beat
  task automatic read_burst(input int addr, input int len, input int mode);
    logic [W-1:0] exp_w [16];
    logic [W-1:0] km    [16];
    int           a;
    int           k;
    int           cyc;
    int           stall;
    for (int j = 0; j <= len; j++) begin
      if (addr >= DEPTH) begin
        exp_w[4'(j)] = {W{1'b0}};
        km[4'(j)]    = {W{1'b1}};
      end else begin
        a = (addr + j) % DEPTH;
        exp_w[4'(j)] = ref_mem[IW'(a)];
        km[4'(j)]    = known[IW'(a)];
      end
    end
    do_req(1'b0, addr, len);
    k = 0; cyc = 0; stall = 0;
    while (k <= len && cyc < 200) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom() % 2);
        default: begin
          rd_ready = !(k == 1 && stall < 3);
          if (!rd_ready) stall++;
        end
      endcase
      if (rd_valid) begin
        check_eq($sformatf("rd_data[%0d]", k), 64'(rd_data & km[4'(k)]),
                 64'(exp_w[4'(k)] & km[4'(k)]));
        check_eq($sformatf("rd_last[%0d]", k), 64'(rd_last), 64'(k == len));
        if (rd_ready) k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_ready = 1'b0;
    check_eq("rd_beats", 64'(k), 64'(len + 1));
    if (mode == 0) check_eq("rd_stream_cycles", 64'(cyc), 64'(len + 2));
    check_eq("rd_idle_valid", 64'(rd_valid), 64'd0);
    check_eq("err_oob", 64'(err_oob), 64'(exp_err));
  endtask

  task automatic fill_random(input int len, input bit full_mask);
    for (int k = 0; k <= len; k++) begin
      wbuf[4'(k)] = W'({$urandom(), $urandom()});
      mbuf[4'(k)] = full_mask ? {LANES{1'b1}} : LANES'($urandom());
    end
  endtask

  initial begin
    int base;
    int addr;
    int len;
    checks    = 0;
    failures  = 0;
    exp_err   = 1'b0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = ADDR_W'(0);
    req_len   = LEN_W'(0);
    wr_valid  = 1'b0;
    wr_data   = {W{1'b0}};
    wr_mask   = {LANES{1'b0}};
    rd_ready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[IW'(i)] = {W{1'b0}};
      known[IW'(i)]   = {W{1'b0}};
    end

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_wr_ready", 64'(wr_ready), 64'd0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_rd_last", 64'(rd_last), 64'd0);
    check_eq("rst_rd_data", 64'(rd_data), 64'd0);
    check_eq("rst_err_oob", 64'(err_oob), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // full-mask burst and streaming read-back
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < LANES; i++) wbuf[4'(k)][i*LANE_W +: LANE_W] = LANE_W'(i + 1 + k);
      mbuf[4'(k)] = {LANES{1'b1}};
    end
    write_burst(16'h10, 3, 1'b0);
    read_burst(16'h10, 3, 0);

    // partial lane mask over a known word
    for (int i = 0; i < LANES; i++) wbuf[0][i*LANE_W +: LANE_W] = LANE_W'(8'h11 * (i + 1));
    mbuf[0] = {LANES{1'b1}};
    write_burst(16'h20, 0, 1'b0);
    wbuf[0] = {LANES{8'hAA}};
    mbuf[0] = 6'b000101;
    write_burst(16'h20, 0, 1'b1);
    read_burst(16'h20, 0, 0);

    read_burst(16'h10, 2, 2);

    // wrap at the top of memory
    fill_random(1, 1'b1);
    write_burst(DEPTH - 1, 1, 1'b1);
    read_burst(DEPTH - 1, 1, 0);
    read_burst(0, 0, 0);

    // out-of-range bursts; 16384+0x10 aliases 0x10 in the low address bits
    read_burst(DEPTH + 5, 0, 0);
    read_burst(16384 + 16'h10, 3, 1);
    fill_random(3, 1'b1);
    write_burst(16384 + 16'h10, 3, 1'b1);
    write_burst(DEPTH + 5, 3, 1'b0);
    read_burst(16'h10, 3, 0);

    // asynchronous reset in the middle of a stalled read burst
    do_req(1'b0, 16'h10, 15);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("mid_rst_rd_last", 64'(rd_last), 64'd0);
    check_eq("mid_rst_rd_data", 64'(rd_data), 64'd0);
    check_eq("mid_rst_err_oob", 64'(err_oob), 64'd0);
    check_eq("mid_rst_req_ready", 64'(req_ready), 64'd1);
    exp_err = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    read_burst(16'h10, 3, 0);

    // randomised traffic in a window straddling the wrap point
    base = DEPTH - 24;
    for (int j = 0; j < 3; j++) begin
      fill_random(15, 1'b1);
      write_burst((base + 16 * j) % DEPTH, 15, 1'b1);
    end
    repeat (30) begin
      if ($urandom() % 8 == 0) addr = DEPTH + int'($urandom() % (131072 - DEPTH));
      else                     addr = (base + int'($urandom() % 48)) % DEPTH;
      len = int'($urandom() % 16);
      if ($urandom() % 2 == 1) begin
        fill_random(len, 1'b0);
        write_burst(addr, len, 1'b1);
      end else begin
        read_burst(addr, len, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
